ulpi_phy_emu: RTL and testbench

//  Synthesizable PHY-side ULPI responder: drives DIR/NXT/data, samples STP, answers link TXCMDs.

---
 rtl/ulpi_phy_emu_pkg.sv | 60 ++++++
 rtl/ulpi_phy_emu_regs.sv | 60 ++++++
 rtl/ulpi_phy_emu.sv | 232 +++++++++++++++++++++++
 tb/tb_ulpi_phy_emu.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ulpi_phy_emu_pkg.sv
// Shared ULPI definitions for the PHY emulator: TXCMD opcodes, RxEvent codes,
// register map with defaults, FSM state codes and the register write request.
package ulpi_phy_emu_pkg;

  localparam logic [1:0] CMD_SPECIAL  = 2'b00;
  localparam logic [1:0] CMD_TRANSMIT = 2'b01;
  localparam logic [1:0] CMD_REG_WR   = 2'b10;
  localparam logic [1:0] CMD_REG_RD   = 2'b11;

  localparam logic [5:0] ADDR_EXTENDED = 6'h2F;

  localparam logic [1:0] RXEV_NONE   = 2'b00;
  localparam logic [1:0] RXEV_ACTIVE = 2'b01;
  localparam logic [1:0] RXEV_ERROR  = 2'b11;

  localparam logic [7:0] VENDOR_ID_LO  = 8'h24;
  localparam logic [7:0] VENDOR_ID_HI  = 8'h04;
  localparam logic [7:0] PRODUCT_ID_LO = 8'h06;
  localparam logic [7:0] PRODUCT_ID_HI = 8'h00;

  // Writable registers, each with base/set/clear aliases at base, base+1, base+2.
  // Index 0 is FUNC_CTRL, then IFC_CTRL, OTG_CTRL, INT_EN_RISE, INT_EN_FALL, SCRATCH.
  localparam int NUM_RW_REGS = 6;
  localparam logic [NUM_RW_REGS-1:0][5:0] RW_REG_BASE =
    {6'h16, 6'h10, 6'h0D, 6'h0A, 6'h07, 6'h04};
  localparam logic [NUM_RW_REGS-1:0][7:0] RW_REG_DEFAULT =
    {8'h00, 8'h1F, 8'h1F, 8'h06, 8'h00, 8'h41};
  localparam int FUNC_CTRL_IDX   = 0;
  localparam int FUNC_RESET_BIT  = 5;

  localparam logic [3:0] S_UTMI_RST  = 4'd0;
  localparam logic [3:0] S_IDLE      = 4'd1;
  localparam logic [3:0] S_CMD_WAIT  = 4'd2;
  localparam logic [3:0] S_REGW_DATA = 4'd3;
  localparam logic [3:0] S_REGW_STP  = 4'd4;
  localparam logic [3:0] S_REGR_TA   = 4'd5;
  localparam logic [3:0] S_REGR_DATA = 4'd6;
  localparam logic [3:0] S_REGR_TB   = 4'd7;
  localparam logic [3:0] S_TX        = 4'd8;
  localparam logic [3:0] S_RX_TA     = 4'd9;
  localparam logic [3:0] S_RX        = 4'd10;
  localparam logic [3:0] S_RX_END    = 4'd11;
  localparam logic [3:0] S_RX_TB     = 4'd12;
  localparam logic [3:0] S_RXCMD_TA  = 4'd13;
  localparam logic [3:0] S_RXCMD     = 4'd14;
  localparam logic [3:0] S_RXCMD_TB  = 4'd15;

  typedef struct packed {
    logic       we;
    logic [5:0] addr;
    logic [7:0] data;
  } reg_wr_t;

  // RXCMD byte: {alt_int,id} , RxEvent, {vbus,linestate}
  function automatic logic [7:0] rxcmd(input logic [1:0] hi, input logic [1:0] ev,
                                       input logic [3:0] lo);
    return {hi, ev, lo};
  endfunction

endpackage

// File: rtl/ulpi_phy_emu_regs.sv
// ULPI register file: address decode, set/clear aliasing, read-only IDs and
// defaults, a one-cycle write port and a combinational read port.
module ulpi_phy_emu_regs
  import ulpi_phy_emu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  reg_wr_t    wr,
  input  logic [5:0] raddr,
  output logic [7:0] rdata,
  output logic       func_rst
);

  logic [NUM_RW_REGS-1:0][7:0] reg_q;
  logic [NUM_RW_REGS-1:0][7:0] reg_d;

  always_comb begin
    reg_d = reg_q;
    for (int i = 0; i < NUM_RW_REGS; i++) begin
      if (wr.we) begin
        if (wr.addr == RW_REG_BASE[i]) begin
          reg_d[i] = wr.data;
        end else if (wr.addr == RW_REG_BASE[i] + 6'd1) begin
          reg_d[i] = reg_q[i] | wr.data;
        end else if (wr.addr == RW_REG_BASE[i] + 6'd2) begin
          reg_d[i] = reg_q[i] & ~wr.data;
        end
      end
    end
    // The reset bit is a trigger only; it never reads back as 1.
    func_rst = reg_d[FUNC_CTRL_IDX][FUNC_RESET_BIT];
    reg_d[FUNC_CTRL_IDX][FUNC_RESET_BIT] = 1'b0;
  end

  always_comb begin
    rdata = 8'h00;
    case (raddr)
      6'h00:   rdata = VENDOR_ID_LO;
      6'h01:   rdata = VENDOR_ID_HI;
      6'h02:   rdata = PRODUCT_ID_LO;
      6'h03:   rdata = PRODUCT_ID_HI;
      default: rdata = 8'h00;
    endcase
    for (int i = 0; i < NUM_RW_REGS; i++) begin
      if ((raddr == RW_REG_BASE[i]) || (raddr == RW_REG_BASE[i] + 6'd1) ||
          (raddr == RW_REG_BASE[i] + 6'd2)) begin
        rdata = reg_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_q <= RW_REG_DEFAULT;
    end else begin
      reg_q <= reg_d;
    end
  end

endmodule

// File: rtl/ulpi_phy_emu.sv
// PHY-side ULPI responder: owns DIR/NXT/data, answers link TXCMDs, captures
// transmit packets and emits injected receive packets and RXCMDs.
module ulpi_phy_emu
  import ulpi_phy_emu_pkg::*;
#(
  parameter int RESET_CYCLES = 8,
  parameter int NXT_DELAY    = 1
) (
  input  logic       CLK_60M,
  input  logic       RST_USB,
  input  logic [7:0] ULPI_DATA_I,
  output logic [7:0] ULPI_DATA_O,
  output logic       ULPI_DATA_OE,
  output logic       ULPI_DIR,
  output logic       ULPI_NXT,
  input  logic       ULPI_STP,
  input  logic [7:0] RX_DATA,
  input  logic       RX_VALID,
  input  logic       RX_LAST,
  input  logic       RX_ERR,
  output logic       RX_READY,
  input  logic [7:0] LINE_STATE,
  output logic       TX_START,
  output logic [3:0] TX_PID,
  output logic [7:0] TX_DATA,
  output logic       TX_STRB,
  output logic       TX_END,
  output logic [7:0] STATE
);

  localparam int         NXT_DLY_EFF = (NXT_DELAY < 1) ? 1 : NXT_DELAY;
  localparam logic [7:0] NXT_ACK     = 8'(NXT_DLY_EFF - 1);
  localparam logic [7:0] RST_LAST    = 8'(RESET_CYCLES);

  logic [3:0] state_q, state_d;
  logic [7:0] rst_cnt_q, rst_cnt_d;
  logic [7:0] dly_q, dly_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] last_sent_q, last_sent_d;
  logic       rx_err_q, rx_err_d;

  reg_wr_t    reg_wr;
  logic [7:0] reg_rdata;
  logic       func_rst;
  logic [7:0] ls_masked;
  logic       cmd_ext;
  logic       unused_ls_bits;

  assign unused_ls_bits = ^LINE_STATE[5:4];
  assign ls_masked      = rxcmd(LINE_STATE[7:6], RXEV_NONE, LINE_STATE[3:0]);
  assign cmd_ext        = cmd_q[7] && (cmd_q[5:0] == ADDR_EXTENDED);
  assign STATE          = {4'h0, state_q};

  // The register write commits on the cycle the link raises STP.
  always_comb begin
    reg_wr.we   = (state_q == S_REGW_STP) && ULPI_STP;
    reg_wr.addr = cmd_q[5:0];
    reg_wr.data = wdata_q;
  end

  ulpi_phy_emu_regs u_regs (
    .clk      (CLK_60M),
    .rst      (RST_USB),
    .wr       (reg_wr),
    .raddr    (cmd_q[5:0]),
    .rdata    (reg_rdata),
    .func_rst (func_rst)
  );

  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = 8'h00;
    dly_d        = dly_q;
    cmd_d        = cmd_q;
    wdata_d      = wdata_q;
    last_sent_d  = last_sent_q;
    rx_err_d     = rx_err_q;
    ULPI_DATA_O  = 8'h00;
    ULPI_DATA_OE = 1'b0;
    ULPI_DIR     = 1'b0;
    ULPI_NXT     = 1'b0;
    RX_READY     = 1'b0;
    TX_START     = 1'b0;
    TX_PID       = 4'h0;
    TX_DATA      = 8'h00;
    TX_STRB      = 1'b0;
    TX_END       = 1'b0;

    case (state_q)
      S_UTMI_RST: begin
        // Counts RESET_CYCLES DIR-high cycles, then one DIR-low turnaround.
        ULPI_DIR = (rst_cnt_q != RST_LAST);
        if (rst_cnt_q == RST_LAST) begin
          state_d = S_IDLE;
        end else begin
          rst_cnt_d = rst_cnt_q + 8'd1;
        end
      end
      S_IDLE: begin
        dly_d = 8'h00;
        if (RX_VALID) begin
          state_d = S_RX_TA;
        end else if (ls_masked != last_sent_q) begin
          state_d = S_RXCMD_TA;
        end else if ((ULPI_DATA_I != 8'h00) && (ULPI_DATA_I[7:6] != CMD_SPECIAL)) begin
          cmd_d   = ULPI_DATA_I;
          state_d = S_CMD_WAIT;
        end
      end
      S_CMD_WAIT: begin
        if (!cmd_ext && (dly_q == NXT_ACK)) begin
          ULPI_NXT = 1'b1;
          case (cmd_q[7:6])
            CMD_TRANSMIT: begin
              TX_START = 1'b1;
              TX_PID   = cmd_q[3:0];
              state_d  = S_TX;
            end
            CMD_REG_WR: state_d = S_REGW_DATA;
            CMD_REG_RD: state_d = S_REGR_TA;
            default:    state_d = S_IDLE;
          endcase
        end else if (ULPI_STP) begin
          state_d = S_IDLE;
        end else if (!cmd_ext) begin
          dly_d = dly_q + 8'd1;
        end
      end
      S_REGW_DATA: begin
        ULPI_NXT = 1'b1;
        if (ULPI_STP) begin
          state_d = S_IDLE;
        end else begin
          wdata_d = ULPI_DATA_I;
          state_d = S_REGW_STP;
        end
      end
      S_REGW_STP: begin
        if (ULPI_STP) begin
          state_d = func_rst ? S_UTMI_RST : S_IDLE;
        end
      end
      S_REGR_TA: begin
        ULPI_DIR = 1'b1;
        state_d  = S_REGR_DATA;
      end
      S_REGR_DATA: begin
        ULPI_DIR     = 1'b1;
        ULPI_DATA_OE = 1'b1;
        ULPI_DATA_O  = reg_rdata;
        state_d      = S_REGR_TB;
      end
      S_REGR_TB: state_d = S_IDLE;
      S_TX: begin
        if (ULPI_STP) begin
          TX_END  = 1'b1;
          state_d = S_IDLE;
        end else begin
          ULPI_NXT = 1'b1;
          TX_STRB  = 1'b1;
          TX_DATA  = ULPI_DATA_I;
        end
      end
      S_RX_TA: begin
        ULPI_DIR = 1'b1;
        ULPI_NXT = 1'b1;
        state_d  = S_RX;
      end
      S_RX: begin
        ULPI_DIR     = 1'b1;
        ULPI_DATA_OE = 1'b1;
        if (RX_VALID) begin
          ULPI_NXT    = 1'b1;
          ULPI_DATA_O = RX_DATA;
          RX_READY    = 1'b1;
          if (RX_LAST) begin
            rx_err_d = RX_ERR;
            state_d  = S_RX_END;
          end
        end else begin
          // Gap cycle: carries the current line state with RxActive.
          ULPI_DATA_O = rxcmd(LINE_STATE[7:6], RXEV_ACTIVE, LINE_STATE[3:0]);
          last_sent_d = ls_masked;
        end
      end
      S_RX_END: begin
        ULPI_DIR     = 1'b1;
        ULPI_DATA_OE = 1'b1;
        ULPI_DATA_O  = rxcmd(LINE_STATE[7:6], rx_err_q ? RXEV_ERROR : RXEV_NONE,
                             LINE_STATE[3:0]);
        last_sent_d  = ls_masked;
        state_d      = S_RX_TB;
      end
      S_RX_TB: state_d = S_IDLE;
      S_RXCMD_TA: begin
        ULPI_DIR = 1'b1;
        state_d  = S_RXCMD;
      end
      S_RXCMD: begin
        ULPI_DIR     = 1'b1;
        ULPI_DATA_OE = 1'b1;
        ULPI_DATA_O  = ls_masked;
        last_sent_d  = ls_masked;
        state_d      = S_RXCMD_TB;
      end
      S_RXCMD_TB: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_60M) begin
    if (RST_USB) begin
      state_q     <= S_UTMI_RST;
      rst_cnt_q   <= 8'h00;
      dly_q       <= 8'h00;
      cmd_q       <= 8'h00;
      wdata_q     <= 8'h00;
      last_sent_q <= 8'h00;
      rx_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      dly_q       <= dly_d;
      cmd_q       <= cmd_d;
      wdata_q     <= wdata_d;
      last_sent_q <= last_sent_d;
      rx_err_q    <= rx_err_d;
    end
  end

endmodule

// File: tb/tb_ulpi_phy_emu.sv
// Directed bench for ulpi_phy_emu: link-side driver tasks, expected-queue
// scoreboards for bus bytes and transmit events, and a final report.
`timescale 1ns/1ps
module tb_ulpi_phy_emu;
  import ulpi_phy_emu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_usb;
  logic [7:0] ulpi_data_i;
  logic [7:0] ulpi_data_o;
  logic       ulpi_data_oe;
  logic       ulpi_dir;
  logic       ulpi_nxt;
  logic       ulpi_stp;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_last;
  logic       rx_err;
  logic       rx_ready;
  logic [7:0] line_state;
  logic       tx_start;
  logic [3:0] tx_pid;
  logic [7:0] tx_data;
  logic       tx_strb;
  logic       tx_end;
  logic [7:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic [9:0] tx_exp_q[$];

  ulpi_phy_emu #(.RESET_CYCLES(8), .NXT_DELAY(1)) dut (
    .CLK_60M      (clk),
    .RST_USB      (rst_usb),
    .ULPI_DATA_I  (ulpi_data_i),
    .ULPI_DATA_O  (ulpi_data_o),
    .ULPI_DATA_OE (ulpi_data_oe),
    .ULPI_DIR     (ulpi_dir),
    .ULPI_NXT     (ulpi_nxt),
    .ULPI_STP     (ulpi_stp),
    .RX_DATA      (rx_data),
    .RX_VALID     (rx_valid),
    .RX_LAST      (rx_last),
    .RX_ERR       (rx_err),
    .RX_READY     (rx_ready),
    .LINE_STATE   (line_state),
    .TX_START     (tx_start),
    .TX_PID       (tx_pid),
    .TX_DATA      (tx_data),
    .TX_STRB      (tx_strb),
    .TX_END       (tx_end),
    .STATE        (state)
  );

  // Clock / watchdog
  always #8 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every PHY-driven bus byte and every transmit event is popped and compared.
  always @(negedge clk) begin
    if (!rst_usb) begin
      if (ulpi_data_oe) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL bus_unexpected: got %02h, expected no bus byte", ulpi_data_o);
        end else begin
          check("bus_byte", {24'h0, ulpi_data_o}, {24'h0, exp_q.pop_front()});
        end
      end
      if (tx_start || tx_strb || tx_end) begin
        logic [9:0] ev;
        ev = tx_start ? {2'd1, 4'h0, tx_pid} : (tx_strb ? {2'd2, tx_data} : {2'd3, 8'h00});
        if (tx_exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL tx_unexpected: got event %03h, expected none", ev);
        end else begin
          check("tx_event", {22'h0, ev}, {22'h0, tx_exp_q.pop_front()});
        end
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    bit found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (state == {4'h0, S_IDLE}) begin
        found = 1'b1;
        break;
      end
    end
    check("wait_idle", {31'h0, found}, 32'h1);
    tick();
  endtask

  task automatic wait_nxt(input string name);
    bit found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ulpi_nxt) begin
        found = 1'b1;
        break;
      end
    end
    check(name, {31'h0, found}, 32'h1);
  endtask

  task automatic reg_write(input logic [5:0] addr, input logic [7:0] data);
    wait_idle();
    ulpi_data_i = {CMD_REG_WR, addr};
    wait_nxt("regw_cmd_nxt");
    tick();
    ulpi_data_i = data;
    @(negedge clk);
    check("regw_data_nxt", {31'h0, ulpi_nxt}, 32'h1);
    tick();
    ulpi_data_i = 8'h00;
    ulpi_stp    = 1'b1;
    tick();
    ulpi_stp    = 1'b0;
  endtask

  task automatic reg_read(input logic [5:0] addr, input logic [7:0] exp);
    wait_idle();
    exp_q.push_back(exp);
    ulpi_data_i = {CMD_REG_RD, addr};
    wait_nxt("regr_cmd_nxt");
    tick();
    ulpi_data_i = 8'h00;
    check("regr_turnaround", {30'h0, ulpi_dir, ulpi_data_oe}, 32'h2);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("regr_dir_release", {31'h0, ulpi_dir}, 32'h0);
  endtask

  task automatic rx_byte(input logic [7:0] d, input logic last, input logic err);
    bit found = 1'b0;
    rx_data  = d;
    rx_valid = 1'b1;
    rx_last  = last;
    rx_err   = err;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rx_ready) begin
        found = 1'b1;
        break;
      end
    end
    check("rx_ready", {31'h0, found}, 32'h1);
    tick();
    rx_valid = 1'b0;
    rx_last  = 1'b0;
    rx_err   = 1'b0;
  endtask

  task automatic rx_packet(input logic err);
    wait_idle();
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h33);
    exp_q.push_back(err ? 8'h30 : 8'h00);
    rx_byte(8'h11, 1'b0, 1'b0);
    rx_byte(8'h22, 1'b0, 1'b0);
    tick();
    rx_byte(8'h33, 1'b1, err);
  endtask

  task automatic count_dir_high(input string name);
    int n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ulpi_dir) n++;
      else break;
    end
    check(name, n, 32'd8);
    check({name, "_ta_oe"}, {31'h0, ulpi_data_oe}, 32'h0);
  endtask

  // Main sequence
  initial begin
    rst_usb     = 1'b1;
    ulpi_data_i = 8'h00;
    ulpi_stp    = 1'b0;
    rx_data     = 8'h00;
    rx_valid    = 1'b0;
    rx_last     = 1'b0;
    rx_err      = 1'b0;
    line_state  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dir", {31'h0, ulpi_dir}, 32'h1);
    check("rst_nxt_oe_rdy", {29'h0, ulpi_nxt, ulpi_data_oe, rx_ready}, 32'h0);
    check("rst_data_o", {24'h0, ulpi_data_o}, 32'h0);
    check("rst_tx", {29'h0, tx_start, tx_strb, tx_end}, 32'h0);
    check("rst_state", {24'h0, state}, {28'h0, S_UTMI_RST});
    tick();
    rst_usb = 1'b0;
    count_dir_high("rst_dir_cycles");
    @(negedge clk);
    check("rst_to_idle", {24'h0, state}, {28'h0, S_IDLE});

    reg_read(6'h00, 8'h24);
    reg_write(6'h04, 8'h45);
    reg_read(6'h04, 8'h45);
    reg_write(6'h05, 8'h02);
    reg_read(6'h04, 8'h47);
    reg_write(6'h06, 8'h40);
    reg_read(6'h04, 8'h07);
    reg_read(6'h0A, 8'h06);
    reg_read(6'h13, 8'h00);
    reg_write(6'h16, 8'hA5);
    reg_write(6'h17, 8'h0A);
    reg_write(6'h18, 8'h05);
    reg_read(6'h16, 8'hAA);

    // FUNC_CTRL.Reset write re-enters the UTMI reset sequence.
    reg_write(6'h04, 8'h61);
    count_dir_high("func_rst_dir_cycles");
    reg_read(6'h04, 8'h41);
    reg_write(6'h00, 8'h55);
    reg_read(6'h00, 8'h24);

    // Transmit capture
    wait_idle();
    tx_exp_q.push_back({2'd1, 4'h0, 4'h3});
    tx_exp_q.push_back({2'd2, 8'hA5});
    tx_exp_q.push_back({2'd2, 8'h5A});
    tx_exp_q.push_back({2'd3, 8'h00});
    ulpi_data_i = 8'h43;
    wait_nxt("tx_cmd_nxt");
    tick();
    ulpi_data_i = 8'hA5;
    tick();
    ulpi_data_i = 8'h5A;
    tick();
    ulpi_data_i = 8'hFF;
    ulpi_stp    = 1'b1;
    tick();
    ulpi_stp    = 1'b0;
    ulpi_data_i = 8'h00;

    rx_packet(1'b0);
    rx_packet(1'b1);

    // Standalone RXCMDs; bits 5:4 of LINE_STATE alone cause no RXCMD.
    wait_idle();
    exp_q.push_back(8'hC1);
    line_state = 8'hC1;
    repeat (6) tick();
    line_state = 8'hF1;
    repeat (6) tick();
    @(negedge clk);
    check("ls_masked_no_rxcmd", {24'h0, state}, {28'h0, S_IDLE});
    exp_q.push_back(8'h00);
    line_state = 8'h00;
    repeat (6) tick();

    // Extended register address: no NXT, link aborts with STP.
    wait_idle();
    ulpi_data_i = 8'hAF;
    begin
      logic nxt_seen = 1'b0;
      repeat (4) begin
        @(negedge clk);
        nxt_seen |= ulpi_nxt;
      end
      check("ext_no_nxt", {31'h0, nxt_seen}, 32'h0);
    end
    tick();
    ulpi_data_i = 8'h00;
    ulpi_stp    = 1'b1;
    tick();
    ulpi_stp    = 1'b0;
    @(negedge clk);
    check("ext_stp_idle", {24'h0, state}, {28'h0, S_IDLE});

    // RX_VALID and a TXCMD in the same idle cycle: receive wins, link retries.
    wait_idle();
    exp_q.push_back(8'h99);
    exp_q.push_back(8'h00);
    ulpi_data_i = 8'hC4;
    rx_data     = 8'h99;
    rx_valid    = 1'b1;
    rx_last     = 1'b1;
    tick();
    ulpi_data_i = 8'h00;
    @(negedge clk);
    check("dirwin_rx_ta", {29'h0, ulpi_dir, ulpi_nxt, ulpi_data_oe}, 32'h6);
    rx_byte(8'h99, 1'b1, 1'b0);
    reg_read(6'h04, 8'h41);

    wait_idle();
    repeat (4) tick();
    check("bus_queue_drained", exp_q.size(), 32'd0);
    check("tx_queue_drained", tx_exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
